mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: merges two requester byte streams into one controller stream.
// Arbitration happens per packet, round-robin. A 1-bit tag FIFO remembers
// which requester issued each read, so every read response returns to that
// requester.
//
// state | meaning
// IDLE  | ctl_empty=1; grant a requester, or sit in the one-cycle hold after a packet
// CMD   | pass the command byte from the granted requester
// LEN   | ctl_empty=1; decode the command byte now on ctl_dout
// BODY  | pass the remaining address/data bytes of the packet
module mem_arbiter #(
  parameter int WIDTH     = 8,
  parameter int TAG_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_empty,
  input  logic             req1_empty,
  input  logic [WIDTH-1:0] req0_dout,
  input  logic [WIDTH-1:0] req1_dout,
  output logic             req0_rd_en,
  output logic             req1_rd_en,
  input  logic             rsp0_full,
  input  logic             rsp1_full,
  output logic [WIDTH-1:0] rsp0_din,
  output logic [WIDTH-1:0] rsp1_din,
  output logic             rsp0_wr_en,
  output logic             rsp1_wr_en,
  output logic             ctl_empty,
  output logic [WIDTH-1:0] ctl_dout,
  input  logic             ctl_rd_en,
  output logic             ctl_full,
  input  logic [WIDTH-1:0] ctl_din,
  input  logic             ctl_wr_en,
  output logic [1:0]       state
);

  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W = $clog2(TAG_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TAG_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [WIDTH-1:0] BYTE_WR  = WIDTH'(49);
  localparam logic [WIDTH-1:0] BYTE_RD  = WIDTH'(48);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_LEN  = 2'd2,
    ST_BODY = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             hold_q, hold_d;
  logic             g_q, g_d;
  logic             last_q, last_d;
  logic [1:0]       rem_q, rem_d;

  logic             tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] cnt_q;
  logic             tag_push, tag_pop, head_tag;

  logic             sel_empty, rd_hs, rd_g;

  assign sel_empty = g_q ? req1_empty : req0_empty;
  assign rd_hs     = ctl_rd_en & ~sel_empty;
  assign ctl_dout  = g_q ? req1_dout : req0_dout;
  assign req0_rd_en = rd_g & ~g_q;
  assign req1_rd_en = rd_g & g_q;
  assign state     = state_q;

  // Response routing: the tag at the head selects the requester TX FIFO.
  assign head_tag   = tag_mem[head_q];
  assign ctl_full   = (cnt_q == '0) ? 1'b1 : (head_tag ? rsp1_full : rsp0_full);
  assign tag_pop    = ctl_wr_en & ~ctl_full;
  assign rsp0_wr_en = tag_pop & ~head_tag;
  assign rsp1_wr_en = tag_pop & head_tag;
  assign rsp0_din   = ctl_din;
  assign rsp1_din   = ctl_din;

  // Packet FSM next-state, grant and pass-through control.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    g_d       = g_q;
    last_d    = last_q;
    rem_d     = rem_q;
    ctl_empty = 1'b1;
    rd_g      = 1'b0;
    tag_push  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hold_q) begin
          // g is still held here so the last popped byte stays on ctl_dout.
          last_d = g_q;
          hold_d = 1'b0;
        end else if ((cnt_q < CNT_FULL) && (~req0_empty || ~req1_empty)) begin
          g_d     = (~req0_empty && ~req1_empty) ? ~last_q : req0_empty;
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        ctl_empty = sel_empty;
        rd_g      = rd_hs;
        if (rd_hs) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (ctl_dout == BYTE_WR) begin
          rem_d   = 2'd2;
          state_d = ST_BODY;
        end else if (ctl_dout == BYTE_RD) begin
          rem_d    = 2'd1;
          tag_push = 1'b1;
          state_d  = ST_BODY;
        end else begin
          rem_d   = 2'd0;
          state_d = ST_IDLE;
          hold_d  = 1'b1;
        end
      end
      ST_BODY: begin
        ctl_empty = sel_empty;
        rd_g      = rd_hs;
        if (rd_hs) begin
          rem_d = rem_q - 2'd1;
          if (rem_q == 2'd1) begin
            state_d = ST_IDLE;
            hold_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and grant registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      hold_q  <= 1'b0;
      g_q     <= 1'b0;
      last_q  <= 1'b1;
      rem_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      g_q     <= g_d;
      last_q  <= last_d;
      rem_q   <= rem_d;
    end
  end

  // Tag FIFO pointers and occupancy; simultaneous push and pop keep the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (tag_push) tail_q <= tail_q + PTR_ONE;
      if (tag_pop)  head_q <= head_q + PTR_ONE;
      case ({tag_push, tag_pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Tag storage; contents are meaningless while the count is zero.
  always_ff @(posedge clk) begin
    if (tag_push) tag_mem[tail_q] <= g_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: requester FIFO models, a small mem_controller model
// and a scoreboard of expected read responses per requester.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0_empty, req1_empty;
  logic [7:0] req0_dout = 8'd0, req1_dout = 8'd0;
  logic       req0_rd_en, req1_rd_en;
  logic       rsp0_full = 1'b0, rsp1_full = 1'b0;
  logic [7:0] rsp0_din, rsp1_din;
  logic       rsp0_wr_en, rsp1_wr_en;
  logic       ctl_empty;
  logic [7:0] ctl_dout;
  logic       ctl_rd_en = 1'b1;
  logic       ctl_full;
  logic [7:0] ctl_din;
  logic       ctl_wr_en;
  logic [1:0] state;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_empty(req0_empty), .req1_empty(req1_empty),
    .req0_dout(req0_dout), .req1_dout(req1_dout),
    .req0_rd_en(req0_rd_en), .req1_rd_en(req1_rd_en),
    .rsp0_full(rsp0_full), .rsp1_full(rsp1_full),
    .rsp0_din(rsp0_din), .rsp1_din(rsp1_din),
    .rsp0_wr_en(rsp0_wr_en), .rsp1_wr_en(rsp1_wr_en),
    .ctl_empty(ctl_empty), .ctl_dout(ctl_dout), .ctl_rd_en(ctl_rd_en),
    .ctl_full(ctl_full), .ctl_din(ctl_din), .ctl_wr_en(ctl_wr_en),
    .state(state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Requester RX FIFOs: data appears the cycle after rd_en.
  logic [7:0] rq0 [256];
  logic [7:0] rq1 [256];
  logic [7:0] rq0_wp = 8'd0, rq0_rp = 8'd0;
  logic [7:0] rq1_wp = 8'd0, rq1_rp = 8'd0;
  assign req0_empty = (rq0_wp == rq0_rp);
  assign req1_empty = (rq1_wp == rq1_rp);

  always @(posedge clk) begin
    if (req0_rd_en) begin
      req0_dout <= rq0[rq0_rp];
      rq0_rp    <= rq0_rp + 8'd1;
    end
    if (req1_rd_en) begin
      req1_dout <= rq1[rq1_rp];
      rq1_rp    <= rq1_rp + 8'd1;
    end
  end

  // mem_controller model: 49 a d writes, 48 a reads, anything else is ignored.
  logic [7:0] mem  [256];
  logic [7:0] pend [256];
  logic [7:0] pw, pr, wa;
  logic [1:0] ps;
  logic       rd_vld;
  assign ctl_wr_en = (pw != pr);
  assign ctl_din   = mem[pend[pr]];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hA5;
      pw <= 8'd0; pr <= 8'd0; wa <= 8'd0; ps <= 2'd0; rd_vld <= 1'b0;
    end else begin
      rd_vld <= ctl_rd_en & ~ctl_empty;
      if (rd_vld) begin
        case (ps)
          2'd0: if (ctl_dout == 8'd49) ps <= 2'd1; else if (ctl_dout == 8'd48) ps <= 2'd3;
          2'd1: begin wa <= ctl_dout; ps <= 2'd2; end
          2'd2: begin mem[wa] <= ctl_dout; ps <= 2'd0; end
          default: begin pend[pw] <= ctl_dout; pw <= pw + 8'd1; ps <= 2'd0; end
        endcase
      end
      if (ctl_wr_en && !ctl_full) pr <= pr + 8'd1;
    end
  end

  // Scoreboard: expected read data per requester, popped on each response push.
  logic [7:0] exp0 [$];
  logic [7:0] exp1 [$];
  logic [7:0] ref_mem [256];

  always @(posedge clk) begin
    if (rst && rsp0_wr_en) begin
      if (exp0.size() == 0) chk("rsp0_extra", 1, 0);
      else chk("rsp0_data", rsp0_din, exp0.pop_front());
    end
    if (rst && rsp1_wr_en) begin
      if (exp1.size() == 0) chk("rsp1_extra", 1, 0);
      else chk("rsp1_data", rsp1_din, exp1.pop_front());
    end
  end

  task automatic push_byte(input bit r, input logic [7:0] b);
    if (r) begin rq1[rq1_wp] = b; rq1_wp = rq1_wp + 8'd1; end
    else   begin rq0[rq0_wp] = b; rq0_wp = rq0_wp + 8'd1; end
  endtask

  task automatic send_wr(input bit r, input logic [7:0] a, input logic [7:0] d);
    push_byte(r, 8'd49); push_byte(r, a); push_byte(r, d);
    ref_mem[a] = d;
  endtask

  task automatic send_rd(input bit r, input logic [7:0] a);
    push_byte(r, 8'd48); push_byte(r, a);
    if (r) exp1.push_back(ref_mem[a]); else exp0.push_back(ref_mem[a]);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    rq0_wp = rq0_rp; rq1_wp = rq1_rp;
    exp0.delete(); exp1.delete();
    rsp0_full = 1'b0; rsp1_full = 1'b0; ctl_rd_en = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'hA5;
    repeat (2) @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_ctl_empty", ctl_empty, 1);
    chk("rst_ctl_full", ctl_full, 1);
    chk("rst_rd_en", {req1_rd_en, req0_rd_en}, 0);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_count(input int n, output int c0, output int c1);
    c0 = 0; c1 = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (req0_rd_en) c0++;
      if (req1_rd_en) c1++;
    end
  endtask

  task automatic wait_done(input int max);
    int quiet = 0;
    for (int i = 0; i < max && quiet < 4; i++) begin
      @(negedge clk);
      if (req0_empty && req1_empty && state == 2'd0 && !ctl_wr_en && !rd_vld) quiet++;
      else quiet = 0;
    end
    if (quiet < 4) chk("timeout_drain", 0, 1);
  endtask

  initial begin
    int c0, c1, f0, f1, sw, cyc;
    bit seen, last_r, hit;

    // Single write packet from req0.
    do_reset();
    send_wr(0, 8'd10, 8'd65);
    run_count(20, c0, c1);
    chk("wr_rd0_pulses", c0, 3);
    chk("wr_rd1_pulses", c1, 0);
    chk("wr_mem10", mem[10], 65);

    // Both requesters preloaded: req0 first, no interleave, 3-cycle overhead.
    do_reset();
    send_wr(0, 8'd20, 8'h11);
    send_wr(1, 8'd21, 8'h22);
    f0 = -1; f1 = -1; sw = 0; seen = 0; last_r = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req0_rd_en) begin
        if (f0 < 0) f0 = i;
        if (seen && last_r) sw++;
        last_r = 0; seen = 1;
      end
      if (req1_rd_en) begin
        if (f1 < 0) f1 = i;
        if (seen && !last_r) sw++;
        last_r = 1; seen = 1;
      end
    end
    chk("rr_req0_first", (f0 >= 0 && f0 < f1), 1);
    chk("rr_gap", f1 - f0, 6);
    chk("rr_switches", sw, 1);
    chk("rr_mem20", mem[20], 8'h11);
    chk("rr_mem21", mem[21], 8'h22);

    // Reads from both requesters return to their issuer.
    do_reset();
    send_rd(1, 8'd10);
    repeat (3) @(negedge clk);
    send_rd(0, 8'd20);
    wait_done(100);
    chk("rd_exp0_left", exp0.size(), 0);
    chk("rd_exp1_left", exp1.size(), 0);
    chk("rd_tag_empty", ctl_full, 1);

    // Tag FIFO full: 9th read waits in IDLE until a response drains.
    do_reset();
    rsp0_full = 1'b1;
    for (int i = 0; i < 9; i++) send_rd(0, 8'(40 + i));
    repeat (80) @(negedge clk);
    chk("full_state", state, 0);
    chk("full_bytes_left", rq0_wp - rq0_rp, 2);
    chk("full_ctl_full", ctl_full, 1);
    chk("full_exp_pending", exp0.size(), 9);
    rsp0_full = 1'b0;
    wait_done(300);
    chk("full_exp0_left", exp0.size(), 0);

    // Command byte arrives, address byte is late: FSM waits in BODY.
    do_reset();
    push_byte(0, 8'd48);
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      if (state == 2'd3) hit = 1;
    end
    chk("stall_reach_body", hit, 1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_state", state, 3);
      chk("stall_ctl_empty", ctl_empty, 1);
      @(negedge clk);
    end
    push_byte(0, 8'd60);
    exp0.push_back(ref_mem[60]);
    wait_done(100);
    chk("stall_exp0_left", exp0.size(), 0);

    // Unknown command byte is a one-byte packet; next read still works.
    do_reset();
    push_byte(0, 8'd7);
    send_rd(0, 8'd30);
    run_count(30, c0, c1);
    chk("unk_rd0_pulses", c0, 3);
    wait_done(100);
    chk("unk_exp0_left", exp0.size(), 0);
    chk("unk_tag_empty", ctl_full, 1);

    // Reset in the middle of a packet aborts at once.
    do_reset();
    send_wr(0, 8'd50, 8'h77);
    hit = 0;
    cyc = 0;
    while (!hit && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (state == 2'd2) hit = 1;
    end
    chk("midrst_reach_len", hit, 1);
    rst = 1'b0;
    #1;
    chk("midrst_state", state, 0);
    chk("midrst_ctl_empty", ctl_empty, 1);
    chk("midrst_ctl_full", ctl_full, 1);
    chk("midrst_rd_en", {req1_rd_en, req0_rd_en}, 0);
    @(negedge clk);
    rq0_wp = rq0_rp;
    rst = 1'b1;
    run_count(10, c0, c1);
    chk("midrst_no_replay", c0 + c1, 0);
    chk("midrst_idle", state, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
